sram_controller: RTL and testbench

- Responder end of the pipeline data-memory interface.
- Accepts the MEM stage's 32-bit read/write requests and serves each as two 16-bit accesses on an external asynchronous SRAM.
- Holds `ready` low until the access completes; the core top ties `freeze` for all stage registers to `~ready`.
- Replaces the single-cycle data memory behind the MEM stage.

---
 rtl/arm_pkg.sv | 6 +
 rtl/sram_wait_counter.sv | 24 ++
 rtl/sram_controller.sv | 116 +++++++++++
 tb/tb_sram_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// arm_pkg: shared types and constants for the data-memory SRAM controller
package arm_pkg;
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} sram_state_t;
    localparam int SRAM_BASE_ADDR = 1024;
    localparam int SRAM_HALF_W    = 16;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: counts 0..WAIT-1 while enabled, flags the last wait cycle
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : force the count back to 0
//   i_en         : advance the count (wraps to 0 after the terminal cycle)
//   o_tc         : high on the last wait cycle (count == WAIT-1)
module sram_wait_counter #(
    parameter int WAIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = WAIT > 1 ? $clog2(WAIT) : 1;
    logic [CW-1:0] r_cnt;
    assign o_tc = r_cnt == CW'(WAIT - 1);
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr || (i_en && o_tc))
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit MEM-stage loads/stores as two 16-bit async SRAM accesses
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_wr_en, i_rd_en      : store / load request (store wins if both set)
//   i_address             : byte address, word 0 of the SRAM sits at BASE_ADDR
//   i_write_data          : store data
//   o_read_data           : load result, held between loads
//   o_ready               : idle or access complete; pipeline freezes while low
//   o_sram_addr           : half-word address {word, half}
//   o_sram_dq_out/_oe     : write data and tristate drive enable
//   i_sram_dq_in          : read data from the SRAM
//   o_sram_we_n           : active-low write strobe
//   o_rd_count/o_wr_count : completed load/store counters, present only when
//                           SRAM_CTRL_STATS_EN is defined, otherwise tied to 0
module sram_controller
    import arm_pkg::*;
#(
    parameter int BASE_ADDR = SRAM_BASE_ADDR,
    parameter int SRAM_WAIT = 4,
    parameter int SRAM_AW   = 18
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  logic                   i_rd_en,
    input  logic [31:0]            i_address,
    input  logic [31:0]            i_write_data,
    output logic [31:0]            o_read_data,
    output logic                   o_ready,
    output logic [SRAM_AW-1:0]     o_sram_addr,
    output logic [SRAM_HALF_W-1:0] o_sram_dq_out,
    input  logic [SRAM_HALF_W-1:0] i_sram_dq_in,
    output logic                   o_sram_dq_oe,
    output logic                   o_sram_we_n,
    output logic [31:0]            o_rd_count,
    output logic [31:0]            o_wr_count
);
    sram_state_t        r_state, w_next;
    logic [SRAM_AW-2:0] r_word;
    logic [31:0]        r_data;
    logic               r_wr;
    logic               w_req, w_tc, w_busy, w_hi;

    assign w_req  = i_wr_en | i_rd_en;
    assign w_busy = (r_state == LOW) | (r_state == HIGH);
    assign w_hi   = r_state == HIGH;

    sram_wait_counter #(.WAIT(SRAM_WAIT)) u_wait (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (~w_busy),
        .i_en  (w_busy),
        .o_tc  (w_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_data      <= '0;
            r_wr        <= 1'b0;
            o_read_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_word <= (SRAM_AW-1)'((i_address - 32'(BASE_ADDR)) >> 2);
                r_data <= i_write_data;
                r_wr   <= i_wr_en;
            end
            if (w_busy && w_tc && !r_wr) begin
                if (w_hi)
                    o_read_data[31:16] <= i_sram_dq_in;
                else
                    o_read_data[15:0]  <= i_sram_dq_in;
            end
        end
    end

    // Strobe releases on the last wait cycle while address/data stay driven,
    // giving hold time against the rising we_n edge.
    always_comb begin
        w_next        = r_state;
        o_ready       = 1'b0;
        o_sram_addr   = '0;
        o_sram_dq_oe  = 1'b0;
        o_sram_we_n   = 1'b1;
        o_sram_dq_out = '0;
        w_next = r_state == IDLE ? (w_req ? LOW : IDLE) :
                 r_state == LOW  ? (w_tc ? HIGH : LOW) :
                 r_state == HIGH ? (w_tc ? DONE : HIGH) : IDLE;
        o_ready       = (r_state == IDLE && !w_req) || r_state == DONE;
        o_sram_addr   = w_busy ? {r_word, w_hi} : '0;
        o_sram_dq_oe  = w_busy & r_wr;
        o_sram_we_n   = ~(w_busy & r_wr & ~w_tc);
        o_sram_dq_out = o_sram_dq_oe ? (w_hi ? r_data[31:16] : r_data[15:0]) : '0;
    end

`ifdef SRAM_CTRL_STATS_EN
    logic [31:0] r_rd_count, r_wr_count;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (r_state == DONE) begin
            if (r_wr)
                r_wr_count <= r_wr_count + 1'b1;
            else
                r_rd_count <= r_rd_count + 1'b1;
        end
    end
    assign o_rd_count = r_rd_count;
    assign o_wr_count = r_wr_count;
`else
    assign o_rd_count = '0;
    assign o_wr_count = '0;
`endif
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: table-driven scoreboard bench for sram_controller
module tb_sram_controller;
    localparam int W = 4;
`ifdef SRAM_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, wr_en, rd_en, ready, oe, we_n, pre;
    logic [31:0] address, write_data, read_data, rd_count, wr_count;
    logic [17:0] sram_addr;
    logic [15:0] dq_out, dq_in;
    logic [15:0] mem [0:1023];

    logic        rd_en1, ready1, oe1, we_n1;
    logic [31:0] address1, read_data1, rd_count1, wr_count1;
    logic [17:0] sram_addr1;
    logic [15:0] dq_out1, dq_in1;

    int n_chk = 0, n_pass = 0, cyc = 0;
    logic [31:0] q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    sram_controller #(.SRAM_WAIT(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_rd_en(rd_en),
        .i_address(address), .i_write_data(write_data), .o_read_data(read_data),
        .o_ready(ready), .o_sram_addr(sram_addr), .o_sram_dq_out(dq_out),
        .i_sram_dq_in(dq_in), .o_sram_dq_oe(oe), .o_sram_we_n(we_n),
        .o_rd_count(rd_count), .o_wr_count(wr_count)
    );

    sram_controller #(.SRAM_WAIT(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(1'b0), .i_rd_en(rd_en1),
        .i_address(address1), .i_write_data(32'h0), .o_read_data(read_data1),
        .o_ready(ready1), .o_sram_addr(sram_addr1), .o_sram_dq_out(dq_out1),
        .i_sram_dq_in(dq_in1), .o_sram_dq_oe(oe1), .o_sram_we_n(we_n1),
        .o_rd_count(rd_count1), .o_wr_count(wr_count1)
    );

    always @(posedge clk) begin
        if (pre) begin
            mem[2] <= 16'h5678;
            mem[3] <= 16'h1234;
        end else if (!we_n)
            mem[sram_addr[9:0]] <= dq_out;
    end
    assign dq_in  = mem[sram_addr[9:0]];
    assign dq_in1 = sram_addr1[0] ? 16'h1111 : 16'h2222;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        #1;
    endtask

    task automatic run(input vec_t v, output int lat, output int bad, output int welo0, output int welo1);
        logic [17:0] ea;
        ea = 18'(((v.addr - 32'd1024) >> 2) << 1);
        bad = 0; welo0 = 0; welo1 = 0; lat = -1;
        @(negedge clk);
        cyc++;
        wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
        q.push_back(v.exp_rd);
        #1;
        chk("accept_ready_low", ready, 0);
        for (int c = 1; c <= 40; c++) begin
            step();
            if (ready) begin
                lat = c;
                break;
            end
            if (c <= 2 * W) begin
                if (sram_addr !== ea + 18'(c > W)) bad++;
                if (v.wr) begin
                    if (oe !== 1'b1) bad++;
                    if (dq_out !== (c > W ? v.wdata[31:16] : v.wdata[15:0])) bad++;
                    if (!we_n) begin
                        if (c > W) welo1++;
                        else welo0++;
                    end
                end else if (oe !== 1'b0 || we_n !== 1'b1) bad++;
            end
        end
        chk("latency", lat, 2 * W + 1);
        chk("read_data_sb", read_data, q.size() > 0 ? q.pop_front() : 32'hxxxx_xxxx);
    endtask

    initial begin
        int lat, bad, w0, w1, prev_done, n_rd, n_wr, idle_hi;
        vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'h0,         32'h1234_5678};
        vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h0,         32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1024, 32'h0000_CAFE, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 1'b1, 32'd1024, 32'h0,         32'h0000_CAFE};
        vecs[5] = '{1'b1, 1'b1, 32'd1032, 32'hA5A5_5A5A, 32'h0000_CAFE};
        vecs[6] = '{1'b0, 1'b1, 32'd1035, 32'h0,         32'hA5A5_5A5A};
        vecs[7] = '{1'b0, 1'b1, 32'd1028, 32'h0,         32'hDEAD_BEEF};
        rst = 1'b1; pre = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        rd_en1 = 1'b0; address1 = 32'd1024;
        step();
        step();
        chk("rst_ready", ready, 1);
        chk("rst_we_n", we_n, 1);
        chk("rst_oe", oe, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq_out", dq_out, 0);
        chk("rst_read_data", read_data, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_wr_count", wr_count, 0);
        rst = 1'b0; pre = 1'b0;
        n_rd = 0; n_wr = 0; prev_done = 0;
        for (int i = 0; i < 8; i++) begin
            run(vecs[i], lat, bad, w0, w1);
            chk($sformatf("bus_v%0d", i), bad, 0);
            if (vecs[i].wr) begin
                chk($sformatf("we_lo_low_v%0d", i), w0, W - 1);
                chk($sformatf("we_lo_high_v%0d", i), w1, W - 1);
                n_wr++;
            end else n_rd++;
            if (i > 0) chk($sformatf("b2b_v%0d", i), cyc - prev_done, 2 * W + 2);
            prev_done = cyc;
        end
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        #1;
        chk("idle_ready", ready, 1);
        chk("rd_count", rd_count, STATS ? 32'(n_rd) : 32'd0);
        chk("wr_count", wr_count, STATS ? 32'(n_wr) : 32'd0);
        @(negedge clk);
        wr_en = 1'b1; address = 32'd1028; write_data = 32'h0BAD_F00D;
        for (int c = 1; c <= W + 2; c++) step();
        chk("midhigh_oe", oe, 1);
        rst = 1'b1; wr_en = 1'b0;
        step();
        rst = 1'b0;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_we_n", we_n, 1);
        chk("mid_rst_oe", oe, 0);
        chk("mid_rst_addr", sram_addr, 0);
        chk("mid_rst_read_data", read_data, 0);
        chk("mid_rst_counts", rd_count | wr_count, 0);
        step();
        chk("post_rst_idle_ready", ready, 1);
        idle_hi = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (ready1) idle_hi++;
        end
        chk("w1_idle_ready", idle_hi, 5);
        @(negedge clk);
        rd_en1 = 1'b1;
        #1;
        chk("w1_accept_ready_low", ready1, 0);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (ready1) begin
                lat = c;
                break;
            end
        end
        chk("w1_latency", lat, 3);
        chk("w1_read_data", read_data1, 32'h1111_2222);
        rd_en1 = 1'b0;
        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
